lcd_hex_writer: RTL

Formats 16-bit values as four ASCII hex characters and writes them into the 32-character LCD character buffer, one character per clock. It sits directly upstream of the LCD controller and drives that block's `writeEnable` / `location` / `data` write port. The LCD controller accepts one write per cycle with no backpressure, so this block never stalls on its output. A small request FIFO lets the datapath post display updates (PC, accumulator, debug registers) without waiting.

---
 rtl/lcd_hex_writer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/lcd_hex_writer.sv
// lcd_hex_writer: formats queued 16-bit values as four ASCII hex characters
// and streams them, one character per clock, into the LCD character buffer.
// A pending clear fills all 32 locations with spaces and is served first.
module lcd_hex_writer #(
  parameter int DEPTH     = 4,
  parameter bit UPPERCASE = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic [2:0]  reqSlot,
  input  logic [15:0] reqValue,
  input  logic        reqBlank,
  input  logic        clearReq,
  output logic        busy,
  output logic        writeEnable,
  output logic [4:0]  location,
  output logic [7:0]  data
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [2:0]  slot;
    logic [15:0] value;
    logic        blank;
  } req_t;

  typedef enum logic [1:0] {IDLE, EMIT, CLEAR} state_t;

  req_t          r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  state_t        r_state, w_state_nxt;
  logic [4:0]    r_idx, w_idx_nxt;
  req_t          r_work, w_work_nxt;
  logic          r_clr_pend;
  logic          w_push, w_pop, w_enter_clear, w_decide;
  logic          w_we;
  logic [4:0]    w_loc;
  logic [7:0]    w_data;
  logic [3:0]    w_nib;

  // Digits map from 0x30; letters are offset so that 10 lands on 'A' or 'a'.
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return (UPPERCASE ? 8'h37 : 8'h57) + {4'h0, n};
  endfunction

  // Full is judged on the registered count, so a same-edge pop never frees a slot.
  assign reqReady = r_count < (AW+1)'(DEPTH);
  assign w_push   = reqValid && reqReady;
  // The final write is still on the bus during the cycle after the last state step.
  assign busy     = (r_state != IDLE) || (r_count != '0) || r_clr_pend || writeEnable;

  // Request storage; contents need no reset since the count qualifies them.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= '{slot: reqSlot, value: reqValue, blank: reqBlank};
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    end
  end

  // Clear request latch; a request arriving during a clear is absorbed by it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            r_clr_pend <= 1'b0;
    else if (w_enter_clear)                r_clr_pend <= 1'b0;
    else if (clearReq && r_state != CLEAR) r_clr_pend <= 1'b1;
  end

  // State, index, working request and the registered LCD write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_work      <= '0;
      writeEnable <= 1'b0;
      location    <= '0;
      data        <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_work      <= w_work_nxt;
      writeEnable <= w_we;
      if (w_we) begin
        location <= w_loc;
        data     <= w_data;
      end
    end
  end

  // Character generation and the shared idle decision, also taken on the last
  // character of a transaction so consecutive transactions have no bubble.
  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_work_nxt    = r_work;
    w_pop         = 1'b0;
    w_enter_clear = 1'b0;
    w_we          = 1'b0;
    w_loc         = '0;
    w_data        = '0;
    w_nib         = '0;
    w_decide      = (r_state == IDLE) ||
                    (r_state == EMIT  && r_idx[1:0] == 2'd3) ||
                    (r_state == CLEAR && r_idx == 5'd31);
    case (r_state)
      EMIT: begin
        case (r_idx[1:0])
          2'd0:    w_nib = r_work.value[15:12];
          2'd1:    w_nib = r_work.value[11:8];
          2'd2:    w_nib = r_work.value[7:4];
          default: w_nib = r_work.value[3:0];
        endcase
        w_we      = 1'b1;
        w_loc     = {r_work.slot, r_idx[1:0]};
        w_data    = r_work.blank ? 8'h20 : hex_ascii(w_nib);
        w_idx_nxt = r_idx + 5'd1;
      end
      CLEAR: begin
        w_we      = 1'b1;
        w_loc     = r_idx;
        w_data    = 8'h20;
        w_idx_nxt = r_idx + 5'd1;
      end
      default: ;
    endcase
    if (w_decide) begin
      w_idx_nxt = '0;
      if (r_clr_pend) begin
        w_state_nxt   = CLEAR;
        w_enter_clear = 1'b1;
      end else if (r_count != '0) begin
        w_state_nxt = EMIT;
        w_pop       = 1'b1;
        w_work_nxt  = r_mem[r_rptr];
      end else begin
        w_state_nxt = IDLE;
      end
    end
  end
endmodule
